// File: rtl/ddr_onchip_frame_reader.sv
// Streams one FRAME_W x FRAME_H RGB frame out of a byte-wide on-chip RAM.
// Each pixel is three consecutive bytes (R, G, B) read with 1-cycle latency.
module ddr_onchip_frame_reader #(
  parameter int FRAME_W   = 100,
  parameter int FRAME_H   = 60,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [14:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [7:0]  mem_writedata,
  output logic        mem_clken,
  input  logic [7:0]  mem_readdata,
  output logic [23:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_sop,
  output logic        src_eop
);

  localparam int unsigned NPIX  = FRAME_W * FRAME_H;
  localparam int          PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [14:0]      ADDR0    = 15'(BASE_ADDR);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    F0,
    F1,
    F2,
    WAIT,
    VALID,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [14:0]      addr_q, addr_d;
  logic [23:0]      data_q, data_d;

  logic last_pix;
  assign last_pix = (pix_q == LAST_PIX);

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = F0;
          pix_d   = '0;
          addr_d  = ADDR0;
        end
      end
      F0: begin
        state_d = F1;
        addr_d  = addr_q + 15'd1;
      end
      // The byte addressed in the previous state is on mem_readdata now.
      F1: begin
        state_d        = F2;
        addr_d         = addr_q + 15'd1;
        data_d[23:16]  = mem_readdata;
      end
      F2: begin
        state_d       = WAIT;
        data_d[15:8]  = mem_readdata;
      end
      WAIT: begin
        state_d      = VALID;
        data_d[7:0]  = mem_readdata;
      end
      VALID: begin
        if (src_ready) begin
          if (last_pix) begin
            state_d = DONE;
          end else begin
            state_d = F0;
            pix_d   = pix_q + PIX_W'(1);
            addr_d  = addr_q + 15'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode the registered state only, so reset clears them at once.
  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign done           = (state_q == DONE);
  assign mem_chipselect = (state_q == F0) || (state_q == F1) || (state_q == F2);
  assign mem_address    = addr_q;
  assign mem_write      = 1'b0;
  assign mem_writedata  = 8'h00;
  assign mem_clken      = 1'b1;
  assign src_valid      = (state_q == VALID);
  assign src_data       = data_q;
  assign src_sop        = src_valid && (pix_q == '0);
  assign src_eop        = src_valid && last_pix;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      assert (3 * NPIX + BASE_ADDR <= 32768)
        else $error("frame does not fit the 15-bit byte address space");
    end
  end
`endif

endmodule

// File: tb/tb_ddr_onchip_frame_reader.sv
// Scoreboard bench for ddr_onchip_frame_reader: default 100x60 frame instance
// plus a 1x1 frame at BASE_ADDR 6, both fed by a byte RAM model.
module tb_ddr_onchip_frame_reader;

  localparam int NPIX = 100 * 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, src_ready;
  logic        busy, done, mem_chipselect, mem_write, mem_clken;
  logic [14:0] mem_address;
  logic [7:0]  mem_writedata, mem_readdata;
  logic [23:0] src_data;
  logic        src_valid, src_sop, src_eop;

  logic        s_start, s_ready;
  logic        s_busy, s_done, s_cs, s_write, s_clken;
  logic [14:0] s_address;
  logic [7:0]  s_writedata, s_readdata;
  logic [23:0] s_data;
  logic        s_valid, s_sop, s_eop;

  logic [7:0] ram [0:32767];

  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
    if (s_cs)           s_readdata   <= ram[s_address];
  end

  ddr_onchip_frame_reader u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop)
  );

  ddr_onchip_frame_reader #(.FRAME_W(1), .FRAME_H(1), .BASE_ADDR(6)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .busy(s_busy), .done(s_done),
    .mem_address(s_address), .mem_chipselect(s_cs),
    .mem_write(s_write), .mem_writedata(s_writedata), .mem_clken(s_clken),
    .mem_readdata(s_readdata), .src_data(s_data), .src_valid(s_valid),
    .src_ready(s_ready), .src_sop(s_sop), .src_eop(s_eop)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {sop, eop, rgb} per pixel and expected fetch addresses.
  logic [25:0] pix_sb  [$];
  logic [14:0] addr_sb [$];
  int hs_cnt   = 0;
  int done_cnt = 0;

  task automatic push_frame(input int base, input int npix);
    for (int p = 0; p < npix; p++) begin
      pix_sb.push_back({p == 0, p == npix - 1,
                        ram[base + 3*p], ram[base + 3*p + 1], ram[base + 3*p + 2]});
      for (int k = 0; k < 3; k++) addr_sb.push_back(15'(base + 3*p + k));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (src_valid && src_ready) begin
        if (pix_sb.size() == 0) check("pix_extra", pix_sb.size(), 1);
        else check("pix", {src_sop, src_eop, src_data}, pix_sb.pop_front());
        hs_cnt++;
      end
      if (mem_chipselect) begin
        if (addr_sb.size() == 0) check("addr_extra", addr_sb.size(), 1);
        else check("addr", mem_address, addr_sb.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic wait_hs(input int target, input int base);
    for (int c = 0; c < 2000 && (hs_cnt - base) < target; c++) @(posedge clk);
    check("wait_hs", hs_cnt - base, target);
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40000; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int first_valid, done_cyc, hs_base, done_base, s_valid_cyc, s_done_cyc, s_n;
    logic [14:0] s_addrs [3];

    for (int i = 0; i < 32768; i++) ram[i] = 8'(i * 37 + (i >> 8)) ^ 8'h5a;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;

    reset_n = 1'b0; start = 1'b0; src_ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctl", {busy, done, src_valid, src_sop, src_eop, mem_chipselect}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", src_data, 0);
    check("const", {mem_write, mem_writedata, mem_clken}, 10'h001);

    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", {busy, mem_chipselect}, 0);

    // 1x1 frame at byte address 6
    s_start = 1'b1; s_n = 0; s_valid_cyc = -1; s_done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) s_start = 1'b0;
      if (s_cs && s_n < 3) begin
        s_addrs[s_n] = s_address;
        s_n++;
      end
      if (s_valid && s_valid_cyc < 0) begin
        s_valid_cyc = c;
        check("s_pix", {s_sop, s_eop, s_data}, {2'b11, ram[6], ram[7], ram[8]});
      end
      if (s_done && s_done_cyc < 0) s_done_cyc = c;
    end
    check("s_naddr", s_n, 3);
    check("s_addr0", s_addrs[0], 6);
    check("s_addr1", s_addrs[1], 7);
    check("s_addr2", s_addrs[2], 8);
    check("s_valid_cyc", s_valid_cyc, 5);
    check("s_done_cyc", s_done_cyc, 6);

    // Full frame with the sink always ready
    done_base = done_cnt;
    push_frame(0, NPIX);
    start = 1'b1; first_valid = -1; done_cyc = -1;
    for (int c = 1; c <= 40000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (src_valid && first_valid < 0) begin
        first_valid = c;
        check("first_pix", {src_sop, src_data}, {1'b1, 24'h112233});
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("first_valid", first_valid, 5);
    check("frame_cycles", done_cyc, 30001);
    check("done_busy", busy, 0);
    check("last_addr", mem_address, 17999);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("f1_dones", done_cnt - done_base, 1);
    check("f1_sb_pix", pix_sb.size(), 0);
    check("f1_sb_addr", addr_sb.size(), 0);

    // Abort with reset in F1 of pixel 50
    hs_base = hs_cnt; done_base = done_cnt;
    push_frame(0, NPIX);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_hs(50, hs_base);
    for (int c = 0; c < 20 && !(mem_chipselect && mem_address == 15'd151); c++)
      @(negedge clk);
    check("f1_of_p50", {mem_chipselect, mem_address}, {1'b1, 15'd151});
    #2 reset_n = 1'b0;
    #1;
    check("abort_ctl", {busy, done, src_valid, src_sop, src_eop, mem_chipselect}, 0);
    check("abort_addr", mem_address, 0);
    check("abort_data", src_data, 0);
    pix_sb.delete();
    addr_sb.delete();
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_nodone", done_cnt - done_base, 0);

    // Frame with a stall on pixel 3 and an ignored start at pixel 10
    hs_base = hs_cnt; done_base = done_cnt;
    push_frame(0, NPIX);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_hs(3, hs_base);
    #1 src_ready = 1'b0;
    for (int c = 0; c < 20 && !src_valid; c++) @(negedge clk);
    check("stall_pix", {src_valid, src_sop, src_eop, src_data},
          {3'b100, ram[9], ram[10], ram[11]});
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("stall_hold", {src_valid, src_sop, src_eop, src_data},
            {3'b100, ram[9], ram[10], ram[11]});
      check("stall_cs", mem_chipselect, 0);
    end
    @(posedge clk);
    #1 src_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume", {mem_chipselect, mem_address}, {1'b1, 15'd12});
    wait_hs(10, hs_base);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(done_cyc);
    check("f3_done_seen", done_cyc > 0, 1);
    check("f3_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("f3_dones", done_cnt - done_base, 1);
    check("f3_idle", {busy, mem_chipselect, src_valid}, 0);
    check("f3_sb_pix", pix_sb.size(), 0);
    check("f3_sb_addr", addr_sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_onchip_frame_reader.md
DDR_ONCHIP_FRAME_READER -- requirements
Module: ddr_onchip_frame_reader

Interface
REQ-001 SHALL have parameter FRAME_W, default 100, pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 60, lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 0, byte address of pixel 0 in the on-chip RAM.
REQ-004 SHALL have port clk  input  1  sole clock; every register samples on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to read one frame; sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted until DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-009 SHALL have port mem_address  output  15  byte address to the RAM slave.
REQ-010 SHALL have port mem_chipselect  output  1  high only in FETCH cycles.
REQ-011 SHALL have port mem_write  output  1  constant 0.
REQ-012 SHALL have port mem_writedata  output  8  constant 0.
REQ-013 SHALL have port mem_clken  output  1  constant 1.
REQ-014 SHALL have port mem_readdata  input  8  RAM read data, valid exactly 1 cycle after its address.
REQ-015 SHALL have port src_data  output  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-016 SHALL have port src_valid  output  1  pixel available.
REQ-017 SHALL have port src_ready  input  1  sink accepts the pixel when src_valid and src_ready are both high.
REQ-018 SHALL have port src_sop  output  1  high with the valid of pixel 0.
REQ-019 SHALL have port src_eop  output  1  high with the valid of pixel FRAME_W*FRAME_H-1.

Function
REQ-020 SHALL implement FSM states IDLE, F0, F1, F2, WAIT, VALID, DONE.
REQ-021 SHALL move from IDLE to F0 on the edge that samples start=1, and SHALL clear the pixel counter and set the byte address to BASE_ADDR.
REQ-022 SHALL drive mem_address = BASE_ADDR + 3*pix + k in state Fk (k = 0..2), with mem_chipselect = 1.
REQ-023 SHALL capture the following bytes: R at the F1 edge, G at the F2 edge, B at the WAIT edge (1-cycle read latency).
REQ-024 SHALL assert src_valid only in VALID and SHALL hold src_data, src_sop and src_eop stable while src_valid=1 and src_ready=0.
REQ-025 SHALL go from VALID to F0 of the next pixel on handshake, or to DONE on handshake of the last pixel.
REQ-026 SHALL make the minimum pixel period 5 cycles, with first src_valid 5 cycles after the start-sampling edge.
REQ-027 SHALL pulse done for exactly one cycle in DONE, with busy low in that cycle, then return to IDLE.
REQ-028 SHALL ignore start whenever the state is not IDLE; no queuing.
REQ-029 SHALL keep the byte address 15 bits wide, and 3*FRAME_W*FRAME_H+BASE_ADDR SHALL be <= 32768; a violation is flagged by a simulation-only assertion.
REQ-030 SHALL assert src_sop and src_eop together in a 1-pixel frame (FRAME_W*FRAME_H = 1).
REQ-031 SHALL keep mem_chipselect low in WAIT, VALID, IDLE and DONE, with mem_address holding its last value.

Reset
REQ-032 SHALL, while reset_n=0, immediately force state IDLE, busy=0, done=0, src_valid=0, src_sop=0, src_eop=0, mem_chipselect=0, mem_address=0, src_data=0 and the pixel counter to 0.
REQ-033 SHALL treat reset mid-frame as an abort: no done pulse and no eop; the next frame starts at pixel 0 on the next start.
REQ-034 SHALL exit reset (rising reset_n) with the first state change no earlier than the first clk edge with start=1.

Verification
REQ-035 SHALL pass this scenario: RAM preloaded with bytes 0x11,0x22,0x33 at 0..2, start pulse, src_ready=1 -> first pixel 0x112233 with sop=1 exactly 5 cycles after start, addresses 0,1,2.
REQ-036 SHALL pass this scenario: full 100x60 frame with src_ready=1 -> 6000 pixels, eop only on the 6000th, done one cycle later, total 30000 cycles + 1, last address 17999.
REQ-037 SHALL pass this scenario: src_ready held 0 for 7 cycles on pixel 3 -> src_data, sop and eop stable, no mem_chipselect activity, resumes F0 after the handshake.
REQ-038 SHALL pass this scenario: start pulsed while busy at pixel 10 -> ignored, frame completes normally, single done pulse.
REQ-039 SHALL pass this scenario: reset_n low mid-pixel in F1 of pixel 50 -> all outputs 0 asynchronously; new start streams from address BASE_ADDR and sop=1.
REQ-040 SHALL pass this scenario: BASE_ADDR=6, FRAME_W=1, FRAME_H=1 -> addresses 6,7,8, single pixel with sop=eop=1, done follows.
